// File: rtl/gfx_pkg.sv
// Shared types and constants for the tile-layer renderer and its VRAM word fetcher.
package gfx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_PTR  = 3'd1,
    FETCH_LINE = 3'd2,
    DRAW       = 3'd3,
    DONE       = 3'd4
  } tile_state_t;

  localparam int TILE_PX         = 8;
  localparam int BYTES_PER_ENTRY = 2;
  localparam int BYTES_PER_LINE  = 2;

  // Phases of the five-cycle two-byte VRAM read
  localparam logic [2:0] C_HI     = 3'd0;
  localparam logic [2:0] C_LO     = 3'd1;
  localparam logic [2:0] C_LATCH1 = 3'd2;
  localparam logic [2:0] C_LO2    = 3'd3;
  localparam logic [2:0] C_LATCH2 = 3'd4;

endpackage

// File: rtl/vram_word_fetch.sv
// Five-cycle two-byte read over the byte-wide VRAM port: presents {byte@A, byte@A+1}
// together with a one-cycle done pulse in the last phase.
module vram_word_fetch import gfx_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        go,
  input  logic [15:0] addr,
  input  logic [7:0]  rdData,
  output logic [7:0]  rdAddr,
  output logic [15:0] word,
  output logic        fetchDone
);

  logic [2:0]  phase_r;
  logic [7:0]  byte0_r;
  logic [15:0] addrNext_s;

  assign addrNext_s = addr + 16'd1;

  // phase sequencing and capture of the first byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= C_HI;
      byte0_r <= 8'h00;
    end else if (clear || !go) begin
      phase_r <= C_HI;
      byte0_r <= 8'h00;
    end else begin
      if (phase_r == C_LATCH2) phase_r <= C_HI;
      else                     phase_r <= phase_r + 3'd1;
      if (phase_r == C_LATCH1) byte0_r <= rdData;
      else                     byte0_r <= byte0_r;
    end
  end

  // address byte mux and word presentation
  always_comb begin
    rdAddr    = 8'h00;
    word      = 16'h0000;
    fetchDone = 1'b0;
    if (go) begin
      case (phase_r)
        C_HI:     rdAddr = addr[15:8];
        C_LO:     rdAddr = addr[7:0];
        C_LATCH1: rdAddr = addrNext_s[15:8];
        C_LO2:    rdAddr = addrNext_s[7:0];
        C_LATCH2: begin
          fetchDone = 1'b1;
          word      = {byte0_r, rdData};
        end
        default:  rdAddr = 8'h00;
      endcase
    end else begin
      rdAddr = 8'h00;
    end
  end

endmodule

// File: rtl/draw_tile_layer.sv
// Tile-layer renderer: walks a VRAM pointer table, fetches 2-bitplane tile lines and
// emits per-pixel frame-buffer writes with scroll offsets and optional colour-0 transparency.
module draw_tile_layer import gfx_pkg::*; #(
  parameter int TILES_X          = 20,
  parameter int TILES_Y          = 15,
  parameter int SCREEN_X         = 160,
  parameter int SCREEN_Y         = 144,
  parameter int TRANSPARENT_ZERO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] table_base,
  input  logic [7:0]  x_offset,
  input  logic [7:0]  y_offset,
  input  logic [7:0]  rd_data,
  output logic [7:0]  rd_addr,
  output logic        draw,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic [1:0]  color,
  output logic        busy,
  output logic        done
);

  tile_state_t state_r, stateNext_s;
  logic [7:0]  tileX_r, tileY_r, nextTileX_s, nextTileY_s, xOff_r, yOff_r;
  logic [7:0]  plane1_r, plane0_r;
  logic [2:0]  line_r, bit_r;
  logic [15:0] ptr_r, base_r, tileIndex_s, fetchAddr_s, fetchWord_s, pixX_s, pixY_s;
  logic [7:0]  fetchRdAddr_s;
  logic [1:0]  pixColor_s;
  logic        startPrev_r, startRise_s, aborting_s, lastTile_s, fetchGo_s, fetchDone_s;

  assign startRise_s = start && !startPrev_r;
  assign aborting_s  = abort && (state_r != IDLE);
  assign lastTile_s  = (tileX_r == 8'(TILES_X - 1)) && (tileY_r == 8'(TILES_Y - 1));
  assign tileIndex_s = 16'(tileY_r) * 16'(TILES_X) + 16'(tileX_r);
  assign fetchGo_s   = (state_r == FETCH_PTR) || ((state_r == FETCH_LINE) && (ptr_r != 16'h0000));
  assign pixX_s      = 16'(tileX_r) * 16'(TILE_PX) + 16'(bit_r) + 16'(xOff_r);
  assign pixY_s      = 16'(tileY_r) * 16'(TILE_PX) + 16'(line_r) + 16'(yOff_r);
  assign pixColor_s  = {plane1_r[3'd7 - bit_r], plane0_r[3'd7 - bit_r]};

  // fetch address for the pointer table entry or the current tile line
  always_comb begin
    case (state_r)
      FETCH_PTR:  fetchAddr_s = base_r + 16'(BYTES_PER_ENTRY) * tileIndex_s;
      FETCH_LINE: fetchAddr_s = ptr_r + 16'(BYTES_PER_LINE) * 16'(line_r);
      default:    fetchAddr_s = 16'h0000;
    endcase
  end

  // row-major tile advance
  always_comb begin
    if (tileX_r == 8'(TILES_X - 1)) begin
      nextTileX_s = 8'd0;
      nextTileY_s = tileY_r + 8'd1;
    end else begin
      nextTileX_s = tileX_r + 8'd1;
      nextTileY_s = tileY_r;
    end
  end

  vram_word_fetch uFetch (
    .clk       (clk),
    .reset     (reset),
    .clear     (aborting_s),
    .go        (fetchGo_s),
    .addr      (fetchAddr_s),
    .rdData    (rd_data),
    .rdAddr    (fetchRdAddr_s),
    .word      (fetchWord_s),
    .fetchDone (fetchDone_s)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= stateNext_s;
  end

  // start history so a held request cannot retrigger a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) startPrev_r <= 1'b0;
    else       startPrev_r <= start;
  end

  // next-state logic; abort overrides every transition
  always_comb begin
    stateNext_s = state_r;
    if (aborting_s) begin
      stateNext_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (startRise_s) stateNext_s = FETCH_PTR;
          else             stateNext_s = IDLE;
        end
        FETCH_PTR: begin
          if (fetchDone_s) stateNext_s = FETCH_LINE;
          else             stateNext_s = FETCH_PTR;
        end
        FETCH_LINE: begin
          if (ptr_r == 16'h0000) stateNext_s = lastTile_s ? DONE : FETCH_PTR;
          else if (fetchDone_s)  stateNext_s = DRAW;
          else                   stateNext_s = FETCH_LINE;
        end
        DRAW: begin
          if (bit_r != 3'd7)       stateNext_s = DRAW;
          else if (line_r != 3'd7) stateNext_s = FETCH_LINE;
          else                     stateNext_s = lastTile_s ? DONE : FETCH_PTR;
        end
        DONE: begin
          if (!start) stateNext_s = IDLE;
          else        stateNext_s = DONE;
        end
        default: stateNext_s = IDLE;
      endcase
    end
  end

  // frame counters, latched frame parameters and fetched tile data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tileX_r <= 8'd0;    tileY_r <= 8'd0;    line_r   <= 3'd0;  bit_r    <= 3'd0;
      ptr_r   <= 16'h0000; base_r <= 16'h0000; plane1_r <= 8'h00; plane0_r <= 8'h00;
      xOff_r  <= 8'd0;    yOff_r  <= 8'd0;
    end else if (aborting_s) begin
      tileX_r <= 8'd0;    tileY_r  <= 8'd0;  line_r   <= 3'd0;  bit_r <= 3'd0;
      ptr_r   <= 16'h0000; plane1_r <= 8'h00; plane0_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: if (startRise_s) begin
          base_r  <= table_base; xOff_r  <= x_offset; yOff_r <= y_offset;
          tileX_r <= 8'd0;       tileY_r <= 8'd0;     line_r <= 3'd0; bit_r <= 3'd0;
        end
        FETCH_PTR: if (fetchDone_s) begin
          ptr_r  <= fetchWord_s;
          line_r <= 3'd0;
        end
        FETCH_LINE: if (ptr_r == 16'h0000) begin
          tileX_r <= nextTileX_s;
          tileY_r <= nextTileY_s;
        end else if (fetchDone_s) begin
          plane1_r <= fetchWord_s[15:8];
          plane0_r <= fetchWord_s[7:0];
          bit_r    <= 3'd0;
        end
        DRAW: begin
          bit_r <= bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            if (line_r != 3'd7) begin
              line_r <= line_r + 3'd1;
            end else begin
              line_r  <= 3'd0;
              tileX_r <= nextTileX_s;
              tileY_r <= nextTileY_s;
            end
          end
        end
        default: begin end
      endcase
    end
  end

  // outputs decoded from state; everything idles at zero
  always_comb begin
    busy    = (state_r == FETCH_PTR) || (state_r == FETCH_LINE) || (state_r == DRAW);
    done    = (state_r == DONE);
    rd_addr = fetchRdAddr_s;
    draw    = 1'b0;
    x_out   = 8'd0;
    y_out   = 8'd0;
    color   = 2'b00;
    if (state_r == DRAW) begin
      x_out = pixX_s[7:0];
      y_out = pixY_s[7:0];
      color = pixColor_s;
      draw  = (pixX_s < 16'(SCREEN_X)) && (pixY_s < 16'(SCREEN_Y)) && !abort &&
              !((TRANSPARENT_ZERO != 0) && (pixColor_s == 2'b00));
    end else begin
      draw = 1'b0;
    end
  end

endmodule
